// File: rtl/char_pixel_pipeline.sv
// Character-cell pixel generator: text buffer fetch -> font ROM fetch -> glyph bit -> RGB,
// with timing sidebands delayed so the output stays pixel-aligned for the HDMI encoder.
module char_pixel_pipeline #(
    parameter int          H_WIDTH    = 12,
    parameter int          V_WIDTH    = 11,
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          ADDR_WIDTH = 12,
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000000,
    parameter int          BLINK_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [H_WIDTH-1:0]    h_count,
    input  logic [V_WIDTH-1:0]    v_count,
    input  logic                  de_in,
    input  logic                  hs_in,
    input  logic                  vs_in,
    input  logic [6:0]            cursor_col,
    input  logic [4:0]            cursor_row,
    output logic [ADDR_WIDTH-1:0] text_addr,
    input  logic [7:0]            text_data,
    output logic [10:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic [23:0]           rgb,
    output logic                  de_out,
    output logic                  hs_out,
    output logic                  vs_out
);
    localparam int CW = H_WIDTH - 3;
    localparam int RW = V_WIDTH - 4;

    // Per-pixel context that travels alongside the memory fetches.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       in_text;
        logic       cursor;
        logic       blink;
        logic [2:0] x_bit;
        logic [3:0] line;
    } pix_t;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [31:0]           addr_full;
    logic                  in_text;
    logic                  cur_hit;
    pix_t                  p1, p2, p3, p4;
    logic                  inv3, inv4;
    logic                  vs_d;
    logic [BLINK_LOG2:0]   frame_cnt;
    logic                  pix_bit;
    logic [23:0]           rgb_next;

    always_comb begin
        col       = h_count[H_WIDTH-1:3];
        row       = v_count[V_WIDTH-1:4];
        addr_full = 32'(row) * 32'(COLS) + 32'(col);
        in_text   = (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
        // Out-of-range cursor positions can only match out-of-range cells, so gate with in_text.
        cur_hit   = in_text && (col == CW'(cursor_col)) && (row == RW'(cursor_row));
    end

    always_comb begin
        pix_bit = font_data[3'd7 - p4.x_bit];
        if (p4.cursor && p4.blink && (p4.line >= 4'd14)) pix_bit = ~pix_bit;
        if (inv4) pix_bit = ~pix_bit;
        rgb_next = 24'h0;
        if (p4.de) rgb_next = (p4.in_text && pix_bit) ? FG_RGB : BG_RGB;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_d      <= 1'b0;
            frame_cnt <= '0;
            text_addr <= '0;
            font_addr <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            p4        <= '0;
            inv3      <= 1'b0;
            inv4      <= 1'b0;
            rgb       <= '0;
            de_out    <= 1'b0;
            hs_out    <= 1'b0;
            vs_out    <= 1'b0;
        end else begin
            vs_d <= vs_in;
            if (vs_in && !vs_d) frame_cnt <= frame_cnt + 1'b1;

            text_addr  <= addr_full[ADDR_WIDTH-1:0];
            p1.de      <= de_in;
            p1.hs      <= hs_in;
            p1.vs      <= vs_in;
            p1.in_text <= in_text;
            p1.cursor  <= cur_hit;
            p1.blink   <= frame_cnt[BLINK_LOG2];
            p1.x_bit   <= h_count[2:0];
            p1.line    <= v_count[3:0];

            p2 <= p1;

            p3        <= p2;
            font_addr <= {text_data[6:0], p2.line};
            inv3      <= text_data[7];

            p4   <= p3;
            inv4 <= inv3;

            rgb    <= rgb_next;
            de_out <= p4.de;
            hs_out <= p4.hs;
            vs_out <= p4.vs;
        end
    end
endmodule

// File: tb/tb_char_pixel_pipeline.sv
// Directed bench for char_pixel_pipeline with registered text/font memory models.
module tb_char_pixel_pipeline;
    localparam logic [23:0] FG = 24'hF0E0D0;
    localparam logic [23:0] BG = 24'h102030;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] h_count = '0;
    logic [10:0] v_count = '0;
    logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
    logic [6:0]  cursor_col = 7'd100;
    logic [4:0]  cursor_row = 5'd31;
    logic [11:0] text_addr;
    logic [7:0]  text_data = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [23:0] rgb;
    logic        de_out, hs_out, vs_out;

    logic [7:0]  text_val = 8'h20;
    logic [7:0]  font_row = 8'h00;
    int          n_chk = 0;
    int          n_pass = 0;

    char_pixel_pipeline #(.FG_RGB(FG), .BG_RGB(BG)) dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .rgb(rgb), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: one cycle from address to data.
    always @(posedge clk) begin
        text_data <= text_val;
        font_data <= font_row;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input int h, input int v, input logic de, input logic hs, input logic vs);
        h_count = 12'(h);
        v_count = 11'(v);
        de_in   = de;
        hs_in   = hs;
        vs_in   = vs;
    endtask

    task automatic query(input int h, input int v, input string tag, input logic [23:0] exp);
        drive(h, v, 1'b1, 1'b0, 1'b0);
        repeat (6) cyc();
        check(tag, rgb, exp);
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 500, 1'b0, 1'b0, 1'b1);
            cyc();
            drive(0, 500, 1'b0, 1'b0, 1'b0);
            cyc();
        end
    endtask

    // One 8-pixel cell of char ch with font row 8'hAA; inv swaps the expected colours.
    task automatic run_cell(input logic [7:0] ch, input logic inv, input string tag);
        text_val = ch;
        font_row = 8'hAA;
        for (int c = 0; c < 13; c++) begin
            if (c < 8) drive(c, 0, 1'b1, 1'b0, 1'b0);
            else       drive(700, 0, 1'b0, 1'b0, 1'b0);
            cyc();
            if (c >= 4 && c < 12)
                check(tag, rgb, (((c - 4) % 2 == 0) ^ inv) ? FG : BG);
        end
    endtask

    logic [2:0] pat [12];

    initial begin
        pat = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b000, 3'b111,
                3'b011, 3'b101, 3'b000, 3'b010, 3'b100, 3'b001};

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            drive(int'($urandom_range(0, 4095)), int'($urandom_range(0, 2047)),
                  1'($urandom), 1'($urandom), 1'($urandom));
            cyc();
            check("rst_rgb", rgb, 0);
            check("rst_side", {de_out, hs_out, vs_out}, 0);
            check("rst_taddr", text_addr, 0);
            check("rst_faddr", font_addr, 0);
        end
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) cyc();
        drive(0, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("first_de", de_out, (k == 5) ? 1 : 0);
        end
        drive(700, 0, 1'b0, 1'b0, 1'b0);
        repeat (6) cyc();

        // Single pixel walk-through: col 2, row 2, line 3, x_bit 1.
        text_val = 8'h41;
        font_row = 8'b0010_0000;
        drive(17, 35, 1'b1, 1'b0, 1'b0);
        cyc();
        check("taddr_162", text_addr, 162);
        repeat (2) cyc();
        check("faddr_413", font_addr, 11'h413);
        repeat (2) cyc();
        check("rgb_x1", rgb, BG);
        drive(700, 0, 1'b0, 1'b0, 1'b0);
        repeat (6) cyc();

        run_cell(8'h41, 1'b0, "cell_A");
        run_cell(8'hC1, 1'b1, "cell_invA");

        // Column 80 is outside the text area; address is not masked.
        text_val = 8'h41;
        font_row = 8'hFF;
        drive(640, 0, 1'b1, 1'b0, 1'b0);
        cyc();
        check("taddr_80", text_addr, 80);
        repeat (5) cyc();
        check("col80_de1", rgb, BG);
        drive(640, 0, 1'b0, 1'b0, 1'b0);
        repeat (6) cyc();
        check("col80_de0", rgb, 0);

        // Sideband pattern delayed by five cycles.
        for (int c = 0; c < 16; c++) begin
            if (c < 12) drive(640, 0, pat[c][2], pat[c][1], pat[c][0]);
            else        drive(640, 0, 1'b0, 1'b0, 1'b0);
            cyc();
            if (c >= 4 && c < 16) check("sideband", {de_out, hs_out, vs_out}, pat[c-4]);
        end

        // Reset while the pipe is full clears outputs immediately.
        drive(0, 0, 1'b1, 1'b1, 1'b0);
        repeat (6) cyc();
        check("pre_rst_de", de_out, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_side", {de_out, hs_out, vs_out}, 0);
        check("mid_rst_rgb", rgb, 0);
        cyc();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();

        // Cursor at (0,0), blank glyph.
        cursor_col = 7'd0;
        cursor_row = 5'd0;
        text_val   = 8'h20;
        font_row   = 8'h00;
        query(0, 14, "cur_cnt0", BG);
        vs_pulses(32);
        query(0, 14, "cur_l14_on", FG);
        query(0, 15, "cur_l15_on", FG);
        query(0, 13, "cur_l13_on", BG);
        query(8, 14, "cur_col1", BG);
        text_val = 8'hA0;
        query(0, 14, "cur_inv_cancel", BG);
        query(8, 14, "inv_nocur", FG);
        text_val = 8'h20;
        vs_pulses(32);
        query(0, 14, "cur_l14_off", BG);
        query(0, 13, "cur_l13_off", BG);
        vs_pulses(32);
        query(0, 14, "cur_l14_96", FG);
        cursor_col = 7'd80;
        query(640, 14, "cur_outside", BG);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
